// File: rtl/ppt_pkg.sv
// Shared definitions for the presentation-controller datapath blocks.
// Holds the freq_meter FSM state encoding, the overflow select code and
// the default period counter width (matching the clock divider counter).
package ppt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } fm_state_t;

  localparam int         FM_SEL_W      = 5;
  localparam logic [4:0] SEL_OVF       = 5'd31;
  localparam int         CNT_W_DEFAULT = 21;

endpackage

// File: rtl/freq_meter_if.sv
// Request/result bus of freq_meter.
//   start        : one-cycle measurement request (requester -> meter)
//   busy         : meter is between start acceptance and result handshake
//   result_valid : result held on period/sel_est/overflow
//   result_ready : requester accepts the result
//   period       : measured period in clk cycles (PERIOD_W bits)
//   sel_est      : estimated divider select code
//   overflow     : no closing edge before the counter saturated
// master = requester side, slave = freq_meter side.
interface freq_meter_if
  import ppt_pkg::*;
#(
  parameter int PERIOD_W = CNT_W_DEFAULT
) ();
  logic                start;
  logic                busy;
  logic                result_valid;
  logic                result_ready;
  logic [PERIOD_W-1:0] period;
  logic [FM_SEL_W-1:0] sel_est;
  logic                overflow;

  modport master (
    output start, result_ready,
    input  busy, result_valid, period, sel_est, overflow
  );

  modport slave (
    input  start, result_ready,
    output busy, result_valid, period, sel_est, overflow
  );
endinterface

// File: rtl/freq_meter_msb_index.sv
// msb_index: combinational leading-one detector.
//   x   : W-bit input value
//   idx : floor(log2(x)); 0 when x is 0 or 1
module msb_index #(
  parameter int W     = 21,
  parameter int IDX_W = 5
) (
  input  logic [W-1:0]     x,
  output logic [IDX_W-1:0] idx
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = 0; i < W; i++) begin
      if (x[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/freq_meter.sv
// freq_meter: measures the period of a slow input in clk cycles and
// estimates the clock-divider select code that would produce it.
//   clk    : the only clock
//   rst_n  : synchronous active-low reset
//   sig_in : asynchronous signal under measurement
//   bus    : freq_meter_if.slave (start/busy, result valid/ready,
//            period, sel_est, overflow)
// Optional feature macro FREQ_METER_AVG_EN: average over 4 consecutive
// periods with a CNT_W+2 accumulator; period port becomes CNT_W+2 bits.
module freq_meter
  import ppt_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sig_in,
  freq_meter_if.slave  bus
);

`ifdef FREQ_METER_AVG_EN
  localparam int ACC_W     = CNT_W + 2;
  localparam int AVG_SHIFT = 2;
`else
  localparam int ACC_W     = CNT_W;
  localparam int AVG_SHIFT = 0;
`endif
  localparam int PERIOD_W = ACC_W;
  localparam int IDX_W    = (CNT_W > 1) ? $clog2(CNT_W) : 1;

  // floor(log2(p)) - 1, clamped to 0 below 4 so a divider tap at bit n
  // (period 2^(n+1)) maps back to n.
  function automatic logic [FM_SEL_W-1:0] sel_from_msb(
    input logic [CNT_W-1:0] p,
    input logic [IDX_W-1:0] msb
  );
    if (p < CNT_W'(4)) return '0;
    return FM_SEL_W'(msb) - FM_SEL_W'(1);
  endfunction

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   rise_q, rise_d;

  fm_state_t              state_q, state_d;
  logic [ACC_W-1:0]       cnt_q, cnt_d;
  logic [PERIOD_W-1:0]    period_q, period_d;
  logic [FM_SEL_W-1:0]    sel_q, sel_d;
  logic                   ovf_q, ovf_d;
`ifdef FREQ_METER_AVG_EN
  logic [1:0]             edge_q, edge_d;
`endif

  logic [CNT_W-1:0]       meas_val;
  logic [IDX_W-1:0]       meas_msb;
  logic                   last_edge;

  // Synchroniser, edge history and a registered rise pulse.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    hist_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

  assign meas_val = CNT_W'(cnt_q >> AVG_SHIFT);

  msb_index #(
    .W     (CNT_W),
    .IDX_W (IDX_W)
  ) u_msb_index (
    .x   (meas_val),
    .idx (meas_msb)
  );

`ifdef FREQ_METER_AVG_EN
  assign last_edge = (edge_q == 2'd3);
`else
  assign last_edge = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    sel_d    = sel_q;
    ovf_d    = ovf_q;
`ifdef FREQ_METER_AVG_EN
    edge_d   = edge_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = ARM;
      end
      ARM: begin
        // This rise opens the window; it can never also close it.
        if (rise_q) begin
          state_d = MEASURE;
          cnt_d   = ACC_W'(1);
`ifdef FREQ_METER_AVG_EN
          edge_d  = 2'd0;
`endif
        end
      end
      MEASURE: begin
        if (rise_q && last_edge) begin
          period_d = PERIOD_W'(meas_val);
          sel_d    = sel_from_msb(meas_val, meas_msb);
          ovf_d    = 1'b0;
          state_d  = DONE;
        end else if (&cnt_q) begin
          period_d = '1;
          sel_d    = SEL_OVF;
          ovf_d    = 1'b1;
          state_d  = DONE;
        end else begin
          // Intermediate edges (averaging only) keep counting through.
          cnt_d = cnt_q + ACC_W'(1);
`ifdef FREQ_METER_AVG_EN
          if (rise_q) edge_d = edge_q + 2'd1;
`endif
        end
      end
      DONE: begin
        if (bus.result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= '0;
      hist_q   <= 1'b0;
      rise_q   <= 1'b0;
      state_q  <= IDLE;
      period_q <= '0;
      sel_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      hist_q   <= hist_d;
      rise_q   <= rise_d;
      state_q  <= state_d;
      period_q <= period_d;
      sel_q    <= sel_d;
      ovf_q    <= ovf_d;
    end
  end

  // Counters are always re-seeded on entry to MEASURE, so no reset needed.
  always_ff @(posedge clk) begin
    cnt_q  <= cnt_d;
`ifdef FREQ_METER_AVG_EN
    edge_q <= edge_d;
`endif
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.result_valid = (state_q == DONE);
  assign bus.period       = period_q;
  assign bus.sel_est      = sel_q;
  assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_freq_meter.sv
// Testbench for freq_meter: scoreboard of expected results, one task per
// scenario, counter width reduced so overflow is reachable quickly.
module tb_freq_meter;
  import ppt_pkg::*;

  localparam int CNT_W = 10;
`ifdef FREQ_METER_AVG_EN
  localparam int PW = CNT_W + 2;
`else
  localparam int PW = CNT_W;
`endif

  typedef struct packed {
    logic [PW-1:0] period;
    logic [4:0]    sel;
    logic          ovf;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic sig_in = 1'b0;

  freq_meter_if #(.PERIOD_W(PW)) fm_if ();

  freq_meter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .bus    (fm_if)
  );

  always #5 clk = ~clk;

  // sig_in generator: square wave cycling through pat[], or a manual level.
  bit gen_on    = 1'b0;
  bit man_level = 1'b0;
  int pat[4]    = '{4, 4, 4, 4};
  int ph        = 0;
  int pi        = 0;
  bit wave      = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (gen_on) begin
        if (ph >= pat[pi]) begin
          ph = 0;
          pi = (pi + 1) % 4;
        end
        wave = (ph < pat[pi] / 2);
        ph++;
      end else begin
        ph   = 0;
        pi   = 0;
        wave = 1'b0;
      end
      sig_in = gen_on ? wave : man_level;
    end
  end

  task automatic set_wave(input int p0, input int p1, input int p2, input int p3);
    gen_on = 1'b0;
    repeat (4) @(negedge clk);
    pat[0] = p0; pat[1] = p1; pat[2] = p2; pat[3] = p3;
    gen_on = 1'b1;
    repeat (2 * (p0 + p1 + p2 + p3) + 8) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    fm_if.start = 1'b1;
    @(negedge clk);
    fm_if.start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (fm_if.result_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (fm_if.busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %b, want 0", fm_if.busy);
    end
    vectors++;
    if (fm_if.result_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid: got %b, want 0", fm_if.result_valid);
    end
    vectors++;
    if (fm_if.overflow !== 1'b0) begin
      miscompares++; $display("FAIL reset_overflow: got %b, want 0", fm_if.overflow);
    end
    vectors++;
    if (fm_if.period !== '0) begin
      miscompares++; $display("FAIL reset_period: got %0d, want 0", fm_if.period);
    end
    vectors++;
    if (fm_if.sel_est !== 5'd0) begin
      miscompares++; $display("FAIL reset_sel: got %0d, want 0", fm_if.sel_est);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_periods();
    int   per_tab[7] = '{2, 3, 4, 7, 8, 64, 100};
    int   sel_tab[7] = '{0, 0, 1, 1, 2, 5, 5};
    exp_t x;
    exp_t e;
    bit   got;
    for (int i = 0; i < 7; i++) begin
      set_wave(per_tab[i], per_tab[i], per_tab[i], per_tab[i]);
      pulse_start();
      x.period = PW'(per_tab[i]);
      x.sel    = 5'(sel_tab[i]);
      x.ovf    = 1'b0;
      sb.push_back(x);
      vectors++;
      if (fm_if.busy !== 1'b1) begin
        miscompares++; $display("FAIL p%0d_busy_after_start: got %b, want 1", per_tab[i], fm_if.busy);
      end
      wait_valid(10 * per_tab[i] + 40, got);
      vectors++;
      if (!got) begin
        miscompares++; $display("FAIL p%0d_valid: timed out, want result_valid 1", per_tab[i]);
        sb.delete();
      end else begin
        e = sb.pop_front();
        vectors++;
        if (fm_if.period !== e.period) begin
          miscompares++; $display("FAIL p%0d_period: got %0d, want %0d", per_tab[i], fm_if.period, e.period);
        end
        vectors++;
        if (fm_if.sel_est !== e.sel) begin
          miscompares++; $display("FAIL p%0d_sel: got %0d, want %0d", per_tab[i], fm_if.sel_est, e.sel);
        end
        vectors++;
        if (fm_if.overflow !== e.ovf) begin
          miscompares++; $display("FAIL p%0d_ovf: got %b, want %b", per_tab[i], fm_if.overflow, e.ovf);
        end
        @(negedge clk);
        vectors++;
        if ({fm_if.result_valid, fm_if.busy} !== 2'b00) begin
          miscompares++; $display("FAIL p%0d_handshake_drop: got valid/busy %b, want 00", per_tab[i], {fm_if.result_valid, fm_if.busy});
        end
      end
    end
    gen_on = 1'b0;
  endtask

  task automatic test_overflow();
    exp_t x;
    exp_t e;
    bit   got;
    gen_on    = 1'b0;
    man_level = 1'b0;
    repeat (6) @(negedge clk);
    pulse_start();
    x.period = '1;
    x.sel    = 5'd31;
    x.ovf    = 1'b1;
    sb.push_back(x);
    man_level = 1'b1;
    repeat (6) @(negedge clk);
    man_level = 1'b0;
    wait_valid(6000, got);
    vectors++;
    if (!got) begin
      miscompares++; $display("FAIL ovf_valid: timed out, want result_valid 1");
      sb.delete();
    end else begin
      e = sb.pop_front();
      vectors++;
      if (fm_if.period !== e.period) begin
        miscompares++; $display("FAIL ovf_period: got %0h, want %0h", fm_if.period, e.period);
      end
      vectors++;
      if (fm_if.sel_est !== e.sel) begin
        miscompares++; $display("FAIL ovf_sel: got %0d, want %0d", fm_if.sel_est, e.sel);
      end
      vectors++;
      if (fm_if.overflow !== e.ovf) begin
        miscompares++; $display("FAIL ovf_flag: got %b, want %b", fm_if.overflow, e.ovf);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    exp_t x;
    exp_t e;
    bit   got;
    bit   seen;
    fm_if.result_ready = 1'b0;
    set_wave(64, 64, 64, 64);
    pulse_start();
    x.period = PW'(64);
    x.sel    = 5'd5;
    x.ovf    = 1'b0;
    sb.push_back(x);
    wait_valid(800, got);
    vectors++;
    if (!got) begin
      miscompares++; $display("FAIL bp_valid: timed out, want result_valid 1");
      sb.delete();
    end else begin
      e = sb.pop_front();
      vectors++;
      if ({fm_if.period, fm_if.sel_est, fm_if.overflow} !== {e.period, e.sel, e.ovf}) begin
        miscompares++; $display("FAIL bp_result: got %0d/%0d/%b, want %0d/%0d/%b",
          fm_if.period, fm_if.sel_est, fm_if.overflow, e.period, e.sel, e.ovf);
      end
      for (int c = 0; c < 10; c++) begin
        fm_if.start = (c == 3);
        @(negedge clk);
        vectors++;
        if ({fm_if.result_valid, fm_if.period, fm_if.sel_est, fm_if.overflow} !== {1'b1, e.period, e.sel, e.ovf}) begin
          miscompares++; $display("FAIL bp_hold_c%0d: got v=%b %0d/%0d/%b, want v=1 %0d/%0d/%b", c,
            fm_if.result_valid, fm_if.period, fm_if.sel_est, fm_if.overflow, e.period, e.sel, e.ovf);
        end
      end
      fm_if.start        = 1'b0;
      fm_if.result_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if ({fm_if.result_valid, fm_if.busy} !== 2'b00) begin
        miscompares++; $display("FAIL bp_release: got valid/busy %b, want 00", {fm_if.result_valid, fm_if.busy});
      end
      vectors++;
      if ({fm_if.period, fm_if.sel_est} !== {e.period, e.sel}) begin
        miscompares++; $display("FAIL bp_keep_after: got %0d/%0d, want %0d/%0d", fm_if.period, fm_if.sel_est, e.period, e.sel);
      end
      seen = 1'b0;
      for (int c = 0; c < 300; c++) begin
        if (fm_if.result_valid === 1'b1 || fm_if.busy === 1'b1) seen = 1'b1;
        @(negedge clk);
      end
      vectors++;
      if (seen) begin
        miscompares++; $display("FAIL bp_ignored_start: got activity after ignored start, want none");
      end
    end
    fm_if.result_ready = 1'b1;
    gen_on = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    gen_on    = 1'b0;
    man_level = 1'b0;
    repeat (6) @(negedge clk);
    pulse_start();
    man_level = 1'b1;
    repeat (6) @(negedge clk);
    man_level = 1'b0;
    repeat (20) @(negedge clk);
    vectors++;
    if (fm_if.busy !== 1'b1) begin
      miscompares++; $display("FAIL rm_busy_measuring: got %b, want 1", fm_if.busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if ({fm_if.busy, fm_if.result_valid} !== 2'b00) begin
      miscompares++; $display("FAIL rm_after_reset: got busy/valid %b, want 00", {fm_if.busy, fm_if.result_valid});
    end
    vectors++;
    if ({fm_if.period, fm_if.sel_est, fm_if.overflow} !== '0) begin
      miscompares++; $display("FAIL rm_outputs_cleared: got %0d/%0d/%b, want 0/0/0", fm_if.period, fm_if.sel_est, fm_if.overflow);
    end
    pat[0] = 16; pat[1] = 16; pat[2] = 16; pat[3] = 16;
    gen_on = 1'b1;
    seen   = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (fm_if.result_valid === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++; $display("FAIL rm_no_result: got result_valid after reset, want none");
    end
    gen_on = 1'b0;
  endtask

`ifdef FREQ_METER_AVG_EN
  task automatic test_avg();
    exp_t x;
    exp_t e;
    bit   got;
    set_wave(100, 102, 98, 100);
    pulse_start();
    x.period = PW'(100);
    x.sel    = 5'd5;
    x.ovf    = 1'b0;
    sb.push_back(x);
    wait_valid(1500, got);
    vectors++;
    if (!got) begin
      miscompares++; $display("FAIL avg_valid: timed out, want result_valid 1");
      sb.delete();
    end else begin
      e = sb.pop_front();
      vectors++;
      if ({fm_if.period, fm_if.sel_est, fm_if.overflow} !== {e.period, e.sel, e.ovf}) begin
        miscompares++; $display("FAIL avg_result: got %0d/%0d/%b, want %0d/%0d/%b",
          fm_if.period, fm_if.sel_est, fm_if.overflow, e.period, e.sel, e.ovf);
      end
      @(negedge clk);
    end
    gen_on = 1'b0;
  endtask
`endif

  initial begin
    fm_if.start        = 1'b0;
    fm_if.result_ready = 1'b1;
    test_reset();
    test_periods();
    test_overflow();
    test_backpressure();
    test_reset_mid();
`ifdef FREQ_METER_AVG_EN
    test_avg();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
